// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: ALU opcode width and the ALU opcode set.
// Opcode 0 and anything above 10 act as a nop (result 0).
package rv32i_pkg;

   localparam int unsigned OPW = 8;

   localparam logic [OPW-1:0] ALU_NOP  = 8'd0;
   localparam logic [OPW-1:0] ALU_ADD  = 8'd1;
   localparam logic [OPW-1:0] ALU_SUB  = 8'd2;
   localparam logic [OPW-1:0] ALU_SLL  = 8'd3;
   localparam logic [OPW-1:0] ALU_SLT  = 8'd4;
   localparam logic [OPW-1:0] ALU_SLTU = 8'd5;
   localparam logic [OPW-1:0] ALU_XOR  = 8'd6;
   localparam logic [OPW-1:0] ALU_SRL  = 8'd7;
   localparam logic [OPW-1:0] ALU_SRA  = 8'd8;
   localparam logic [OPW-1:0] ALU_OR   = 8'd9;
   localparam logic [OPW-1:0] ALU_AND  = 8'd10;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two requesters and alu_arbiter.
//   req_valid/req_ready  per-port request handshake
//   req0_*/req1_*        operands and opcode per port
//   rsp_valid/rsp_ready  per-port response handshake
//   rsp_res              shared result, meaningful where rsp_valid is set
// master: requester side, slave: arbiter side.
interface alu_arbiter_if
   import rv32i_pkg::*;
#(
   parameter int unsigned WIDTH = 32
);

   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [WIDTH-1:0] req0_data1;
   logic [WIDTH-1:0] req0_data2;
   logic [OPW-1:0]   req0_op;
   logic [WIDTH-1:0] req1_data1;
   logic [WIDTH-1:0] req1_data2;
   logic [OPW-1:0]   req1_op;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_ready;
   logic [WIDTH-1:0] rsp_res;

   modport master (
      output req_valid, req0_data1, req0_data2, req0_op,
      output req1_data1, req1_data2, req1_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_res
   );

   modport slave (
      input  req_valid, req0_data1, req0_data2, req0_op,
      input  req1_data1, req1_data2, req1_op, rsp_ready,
      output req_ready, rsp_valid, rsp_res
   );

endinterface

// File: rtl/alu.sv
// Combinational RV32I-style ALU.
//   a, b  operands
//   op    opcode from rv32i_pkg; unknown opcodes give 0
//   res   result
module alu
   import rv32i_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OPW-1:0]   op,
   output logic [WIDTH-1:0] res
);

   localparam int unsigned SHW = $clog2(WIDTH);

   logic [SHW-1:0] shamt;
   logic           lt_s;
   logic           lt_u;

   assign shamt = b[SHW-1:0];
   assign lt_s  = $signed(a) < $signed(b);
   assign lt_u  = a < b;

   always_comb begin
      res = '0;
      unique case (op)
         ALU_ADD:  res = a + b;
         ALU_SUB:  res = a - b;
         ALU_SLL:  res = a << shamt;
         ALU_SLT:  res = {{(WIDTH-1){1'b0}}, lt_s};
         ALU_SLTU: res = {{(WIDTH-1){1'b0}}, lt_u};
         ALU_XOR:  res = a ^ b;
         ALU_SRL:  res = a >> shamt;
         ALU_SRA:  res = $unsigned($signed(a) >>> shamt);
         ALU_OR:   res = a | b;
         ALU_AND:  res = a & b;
         default:  res = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters (0: execute,
// 1: address/branch-target). Granted operands are registered and fed to
// u_alu; the result is held until its owner consumes it.
//   clk, rst_n  clock and synchronous active-low reset
//   bus         alu_arbiter_if slave: request and response handshakes
module alu_arbiter
   import rv32i_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_arbiter_if.slave  bus
);

   logic             busy_q, busy_d;
   logic             owner_q, owner_d;
   logic             rr_last_q, rr_last_d;
   logic [WIDTH-1:0] d1_q, d1_d;
   logic [WIDTH-1:0] d2_q, d2_d;
   logic [OPW-1:0]   op_q, op_d;

   logic             free;
   logic [1:0]       grant;
   logic [1:0]       req_ready;
   logic             accept;
   logic             acc_port;
   logic [WIDTH-1:0] alu_res;

   // rsp_valid[owner] is just busy, so the slot frees when idle or when
   // the owner consumes this cycle.
   assign free = !busy_q || bus.rsp_ready[owner_q];

   // With both requesting, the port that did not win last time goes.
   assign grant[0] = bus.req_valid[0] && (!bus.req_valid[1] || rr_last_q);
   assign grant[1] = bus.req_valid[1] && (!bus.req_valid[0] || !rr_last_q);

   assign req_ready     = {2{free}} & grant;
   assign bus.req_ready = req_ready;
   assign accept        = |req_ready;
   assign acc_port      = req_ready[1];

   always_comb begin
      busy_d    = busy_q;
      owner_d   = owner_q;
      rr_last_d = rr_last_q;
      d1_d      = d1_q;
      d2_d      = d2_q;
      op_d      = op_q;
      if (accept) begin
         busy_d    = 1'b1;
         owner_d   = acc_port;
         rr_last_d = acc_port;
         d1_d      = acc_port ? bus.req1_data1 : bus.req0_data1;
         d2_d      = acc_port ? bus.req1_data2 : bus.req0_data2;
         op_d      = acc_port ? bus.req1_op    : bus.req0_op;
      end else if (busy_q && bus.rsp_ready[owner_q]) begin
         busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q    <= 1'b0;
         owner_q   <= 1'b0;
         rr_last_q <= 1'b1;
         d1_q      <= '0;
         d2_q      <= '0;
         op_q      <= '0;
      end else begin
         busy_q    <= busy_d;
         owner_q   <= owner_d;
         rr_last_q <= rr_last_d;
         d1_q      <= d1_d;
         d2_q      <= d2_d;
         op_q      <= op_d;
      end
   end

   assign bus.rsp_valid[0] = busy_q && !owner_q;
   assign bus.rsp_valid[1] = busy_q && owner_q;

   alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .a   (d1_q),
      .b   (d2_q),
      .op  (op_q),
      .res (alu_res)
   );

   assign bus.rsp_res = alu_res;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: per-port request queues drive the
// DUT, accepted requests push an expected result to a scoreboard, and
// consumed responses pop and compare against it.
module tb_alu_arbiter;
   import rv32i_pkg::*;

   typedef struct {
      logic [7:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } req_t;

   typedef struct {
      logic        port;
      logic [31:0] res;
   } exp_t;

   logic clk;
   logic rst_n;

   alu_arbiter_if #(.WIDTH(32)) bus ();

   alu_arbiter #(
      .WIDTH (32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_vec;
   int   n_err;
   req_t q0[$];
   req_t q1[$];
   exp_t sb[$];
   int   grant_log[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(logic [7:0] op, logic [31:0] a, logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         8'd1:    return a + b;
         8'd2:    return a - b;
         8'd3:    return a << sh;
         8'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         8'd5:    return (a < b) ? 32'd1 : 32'd0;
         8'd6:    return a ^ b;
         8'd7:    return a >> sh;
         8'd8:    return $unsigned($signed(a) >>> sh);
         8'd9:    return a | b;
         8'd10:   return a & b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic push(input int port, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b);
      req_t r;
      r.op = op;
      r.a  = a;
      r.b  = b;
      if (port == 0) q0.push_back(r);
      else q1.push_back(r);
   endtask

   task automatic apply_reqs();
      bus.req_valid[0] = (q0.size() != 0);
      bus.req_valid[1] = (q1.size() != 0);
      bus.req0_op      = (q0.size() != 0) ? q0[0].op : 8'd0;
      bus.req0_data1   = (q0.size() != 0) ? q0[0].a  : 32'd0;
      bus.req0_data2   = (q0.size() != 0) ? q0[0].b  : 32'd0;
      bus.req1_op      = (q1.size() != 0) ? q1[0].op : 8'd0;
      bus.req1_data1   = (q1.size() != 0) ? q1[0].a  : 32'd0;
      bus.req1_data2   = (q1.size() != 0) ? q1[0].b  : 32'd0;
   endtask

   // Called away from the edge with inputs settled: score this cycle's
   // handshakes, cross the rising edge, then drive the next requests.
   task automatic tick();
      logic       in_rst;
      logic [1:0] acc;
      exp_t       e;
      exp_t       got;
      in_rst = !rst_n;
      acc    = 2'b00;
      if (!in_rst) begin
         for (int i = 0; i < 2; i++) begin
            if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
               if (sb.size() == 0) begin
                  check("unexpected_rsp", 64'(i), 64'hFFFF);
               end else begin
                  e = sb.pop_front();
                  got.port = i[0];
                  check("rsp_port", 64'(got.port), 64'(e.port));
                  check("rsp_res", 64'(bus.rsp_res), 64'(e.res));
               end
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
               acc[i] = 1'b1;
               e.port = i[0];
               e.res  = (i == 0) ? model(q0[0].op, q0[0].a, q0[0].b)
                                 : model(q1[0].op, q1[0].a, q1[0].b);
               sb.push_back(e);
               grant_log.push_back(i);
            end
         end
      end
      @(posedge clk);
      #1;
      if (in_rst) sb.delete();
      if (acc[0]) void'(q0.pop_front());
      if (acc[1]) void'(q1.pop_front());
      apply_reqs();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         check("rst_req_ready", 64'(bus.req_ready), 64'd0);
         check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
         check("rst_rsp_res", 64'(bus.rsp_res), 64'd0);
      end
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.rsp_ready = 2'b00;
      apply_reqs();
      @(negedge clk);

      // Reset, then a single add on port 0.
      do_reset();
      bus.rsp_ready = 2'b01;
      push(0, ALU_ADD, 32'd5, 32'd7);
      apply_reqs();
      #1;
      check("single_req_ready", 64'(bus.req_ready), 64'b01);
      tick();
      check("single_rsp_valid", 64'(bus.rsp_valid), 64'b01);
      check("single_rsp_res", 64'(bus.rsp_res), 64'd12);
      tick();

      // Contention straight out of reset: port 0 first.
      do_reset();
      bus.rsp_ready = 2'b11;
      push(0, ALU_SUB, 32'd10, 32'd3);
      push(1, ALU_XOR, 32'hF0, 32'h0F);
      apply_reqs();
      #1;
      check("cont_ready0", 64'(bus.req_ready), 64'b01);
      tick();
      check("cont_valid0", 64'(bus.rsp_valid), 64'b01);
      check("cont_res0", 64'(bus.rsp_res), 64'd7);
      check("cont_ready1", 64'(bus.req_ready), 64'b10);
      tick();
      check("cont_valid1", 64'(bus.rsp_valid), 64'b10);
      check("cont_res1", 64'(bus.rsp_res), 64'hFF);
      tick();

      // Back-pressure: port 1 owner stalls 3 cycles while port 0 waits.
      bus.rsp_ready = 2'b01;
      push(1, ALU_SRA, 32'h8000_0000, 32'd4);
      apply_reqs();
      #1;
      check("bp_ready1", 64'(bus.req_ready), 64'b10);
      tick();
      push(0, ALU_ADD, 32'd1, 32'd1);
      apply_reqs();
      #1;
      for (int k = 0; k < 3; k++) begin
         check("bp_stall_ready", 64'(bus.req_ready), 64'b00);
         check("bp_stall_valid", 64'(bus.rsp_valid), 64'b10);
         check("bp_stall_res", 64'(bus.rsp_res), 64'hF800_0000);
         tick();
      end
      bus.rsp_ready = 2'b11;
      #1;
      check("bp_release_ready", 64'(bus.req_ready), 64'b01);
      tick();
      check("bp_next_valid", 64'(bus.rsp_valid), 64'b01);
      check("bp_next_res", 64'(bus.rsp_res), 64'd2);
      tick();

      // Fairness: both ports loaded with 4 ops each.
      grant_log.delete();
      for (int k = 0; k < 4; k++) begin
         push(0, ALU_OR, 32'(k * 3), 32'h100);
         push(1, ALU_SLL, 32'(k + 1), 32'(k));
      end
      apply_reqs();
      #1;
      for (int k = 0; k < 9; k++) tick();
      check("fair_grants", 64'(grant_log.size()), 64'd8);
      for (int k = 1; k < grant_log.size(); k++) begin
         check("fair_alternate", 64'(grant_log[k]), 64'(grant_log[0] ^ (k & 1)));
      end

      // Opcode outside 1..10 is accepted and yields 0.
      push(0, 8'h2A, 32'd3, 32'd4);
      apply_reqs();
      #1;
      check("illegal_ready", 64'(bus.req_ready), 64'b01);
      tick();
      check("illegal_valid", 64'(bus.rsp_valid), 64'b01);
      check("illegal_res", 64'(bus.rsp_res), 64'd0);
      tick();

      // Reset while a result is pending discards it.
      bus.rsp_ready = 2'b00;
      push(0, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
      apply_reqs();
      #1;
      tick();
      check("midrst_pending_res", 64'(bus.rsp_res), 64'd1);
      rst_n = 1'b0;
      #1;
      tick();
      check("midrst_valid", 64'(bus.rsp_valid), 64'b00);
      check("midrst_res", 64'(bus.rsp_res), 64'd0);
      rst_n = 1'b1;
      bus.rsp_ready = 2'b11;
      push(0, ALU_ADD, 32'd20, 32'd22);
      apply_reqs();
      #1;
      tick();
      check("midrst_after_valid", 64'(bus.rsp_valid), 64'b01);
      check("midrst_after_res", 64'(bus.rsp_res), 64'd42);
      tick();
      tick();

      check("sb_drained", 64'(sb.size()), 64'd0);
      check("reqs_drained", 64'(q0.size() + q1.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
